// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
//
// 640x480 VGA timing generator and pixel scan-out stage, clocked from the
// 50 MHz system clock. A clock divider produces one dot every CLK_DIV clk
// cycles. On each active dot one 12-bit RGB word is popped from the upstream
// line-buffer FIFO and placed on the VGA colour pins. The block also tells
// the SDRAM line fetcher which line to fetch next, and when a frame's
// vertical blank begins, so the fetcher can stay one line ahead.
//
// Ports
//   clk              system clock (CLOCK_50 domain)
//   reset            asynchronous, active-low reset
//   pixel_data       upstream pixel {R[11:8], G[7:4], B[3:0]}
//   pixel_valid      pixel_data holds a valid pixel
//   pixel_ready      one-clk pop strobe; a word is consumed when
//                    pixel_valid && pixel_ready
//   line_request     one-clk pulse: fetch line line_number now
//   line_number      line index for line_request, held until the next one
//   vblank_start     one-clk pulse at the first blank line of a frame
//   underflow        sticky flag: a pixel was missing at an active dot
//   underflow_clear  clears underflow (a new miss in the same clk wins)
//   VGA_R/G/B        4-bit colour outputs
//   VGA_HS, VGA_VS   sync outputs, active-low
//   VGA_PIXEL_CLOCK  dot clock, clk/CLK_DIV, rising edge in mid-dot
// ---------------------------------------------------------------------------
module vga_scanout #(
    parameter int H_ACTIVE = 640,  // visible dots per line
    parameter int H_FRONT  = 16,   // horizontal front porch (dots)
    parameter int H_SYNC   = 96,   // HS pulse width (dots)
    parameter int H_BACK   = 48,   // horizontal back porch (dots)
    parameter int V_ACTIVE = 480,  // visible lines per frame
    parameter int V_FRONT  = 11,   // vertical front porch (lines)
    parameter int V_SYNC   = 2,    // VS pulse width (lines)
    parameter int V_BACK   = 31,   // vertical back porch (lines)
    parameter int CLK_DIV  = 2     // clk cycles per dot (even, >= 2)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic        line_request,
    output logic [9:0]  line_number,
    output logic        vblank_start,
    output logic        underflow,
    input  logic        underflow_clear,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_PIXEL_CLOCK
);

    // -----------------------------------------------------------------------
    // Derived geometry
    // -----------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam int DW = $clog2(CLK_DIV);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [DW-1:0] D_LAST   = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] D_HALF   = DW'(CLK_DIV / 2);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);

    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DW-1:0] d;       // position inside the current dot
    logic [HW-1:0] h;       // dot within the line
    logic [VW-1:0] v;       // line within the frame

    // -----------------------------------------------------------------------
    // Decode of the current position
    // -----------------------------------------------------------------------
    logic [DW-1:0] d_next;
    logic [VW-1:0] v_succ;      // (v + 1) mod V_TOTAL
    logic          pix_en;      // last clk of the dot: everything advances
    logic          active;      // current (h,v) is inside the visible area
    logic          hs_n;        // HS level for the current dot
    logic          vs_n;        // VS level for the current dot
    logic          line_wanted; // this line's request slot, next line visible
    logic          pop;         // take one word from upstream this clk

    always_comb begin
        // NOTE: every signal here is assigned on every path, so no latch can
        // be inferred; conditional values are expressed with ?: rather than
        // a partial if.
        pix_en      = (d == D_LAST);
        d_next      = pix_en ? '0 : d + 1'b1;
        active      = (h < H_VIS) && (v < V_VIS);
        hs_n        = !((h >= HS_BEGIN) && (h < HS_END));
        vs_n        = !((v >= VS_BEGIN) && (v < VS_END));
        v_succ      = (v == V_LAST) ? '0 : v + 1'b1;
        line_wanted = (h == H_VIS) && (v_succ < V_VIS);
        pop         = pix_en && active;
    end

    // The pop strobe is decoded straight from registered state, so it is
    // high during the pix_en clk itself and the word is captured at the end
    // of that same clk. It can never be high outside a pix_en clk.
    assign pixel_ready = pop;

    // -----------------------------------------------------------------------
    // Dot divider, dot clock and raster counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of block order.
        if (!reset) begin
            d               <= '0;
            h               <= '0;
            v               <= '0;
            VGA_PIXEL_CLOCK <= 1'b0;
        end else begin
            d <= d_next;
            // High for the second half of each dot: the rising edge lands in
            // the middle of the dot, where the colour pins are stable.
            VGA_PIXEL_CLOCK <= (d_next >= D_HALF);
            if (pix_en) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= v_succ;
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Colour and sync outputs
    //
    // RGB, HS and VS are all loaded on the same pix_en edge from the same
    // (h,v), so they reach the pins together one clk after the pop.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            VGA_R  <= '0;
            VGA_G  <= '0;
            VGA_B  <= '0;
            VGA_HS <= 1'b1;
            VGA_VS <= 1'b1;
        end else if (pix_en) begin
            if (pop && pixel_valid) begin
                VGA_R <= pixel_data[11:8];
                VGA_G <= pixel_data[7:4];
                VGA_B <= pixel_data[3:0];
            end else begin
                // Blanking, or a missing pixel: show black.
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
            VGA_HS <= hs_n;
            VGA_VS <= vs_n;
        end
    end

    // -----------------------------------------------------------------------
    // Fetcher handshake
    //
    // The request for line n goes out when the current line's visible part
    // ends (h == H_ACTIVE), one full blanking interval ahead of line n.
    // Line 0 is therefore requested from the last line of the frame, and no
    // requests are made while the following line is a blank one.
    // line_number is loaded on the same edge that raises line_request, so
    // the fetcher sees both together.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_request <= 1'b0;
            line_number  <= '0;
            vblank_start <= 1'b0;
        end else begin
            line_request <= pix_en && line_wanted;
            vblank_start <= pix_en && (h == '0) && (v == V_VIS);
            if (pix_en && line_wanted) begin
                line_number <= 10'(v_succ);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Underflow flag
    //
    // Sticky until cleared; a miss in the same clk as a clear wins so that
    // no event is ever lost. Timing keeps running through an underflow.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underflow <= 1'b0;
        end else if (pop && !pixel_valid) begin
            underflow <= 1'b1;
        end else if (underflow_clear) begin
            underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// ---------------------------------------------------------------------------
// tb_vga_scanout
//
// Directed bench for vga_scanout. Two instances share clk and reset:
//   big   - the 640x480 / CLK_DIV=2 configuration, fed a counter pattern,
//           with pixel misses and underflow clears at chosen dots
//   small - a tiny raster (15x10 dots, CLK_DIV=4) so whole frames run in a
//           few hundred clk and frame-level behaviour can be counted
// A timing model computes, from the number of clk edges since reset release,
// what every output must be; hand-computed directed checks sit on top.
// ---------------------------------------------------------------------------
module tb_vga_scanout;

    // Small-instance geometry: H 8/2/3/2 = 15 dots, V 6/1/2/1 = 10 lines.
    localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VA = 6, S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int S_DIV = 4;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, div;
    } geom_t;

    // Observed outputs of one instance.
    typedef struct {
        logic        ready, pclk, lr, vb, uf, hs, vs;
        logic [11:0] rgb;
        logic [9:0]  ln;
    } obs_t;

    // Expected register contents plus what the next edge will load.
    typedef struct {
        logic [11:0] rgb, rgb_next;
        logic        hs, vs, hs_next, vs_next;
        logic [9:0]  ln, ln_next;
        logic        uf;
        bit          load, set_uf, clr_uf, lr_pend, vb_pend;
    } model_t;

    logic        clk;
    logic        reset;

    logic [11:0] pixel_data;
    logic        pixel_valid, underflow_clear;
    logic        pixel_ready, line_request, vblank_start, underflow;
    logic [9:0]  line_number;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_pclk;

    logic [11:0] pixel_data_s;
    logic        pixel_valid_s, underflow_clear_s;
    logic        pixel_ready_s, line_request_s, vblank_start_s, underflow_s;
    logic [9:0]  line_number_s;
    logic [3:0]  vga_r_s, vga_g_s, vga_b_s;
    logic        vga_hs_s, vga_vs_s, vga_pclk_s;

    vga_scanout dut (
        .clk             (clk),
        .reset           (reset),
        .pixel_data      (pixel_data),
        .pixel_valid     (pixel_valid),
        .pixel_ready     (pixel_ready),
        .line_request    (line_request),
        .line_number     (line_number),
        .vblank_start    (vblank_start),
        .underflow       (underflow),
        .underflow_clear (underflow_clear),
        .VGA_R           (vga_r),
        .VGA_G           (vga_g),
        .VGA_B           (vga_b),
        .VGA_HS          (vga_hs),
        .VGA_VS          (vga_vs),
        .VGA_PIXEL_CLOCK (vga_pclk)
    );

    vga_scanout #(
        .H_ACTIVE (S_HA), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_ACTIVE (S_VA), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .CLK_DIV  (S_DIV)
    ) dut_s (
        .clk             (clk),
        .reset           (reset),
        .pixel_data      (pixel_data_s),
        .pixel_valid     (pixel_valid_s),
        .pixel_ready     (pixel_ready_s),
        .line_request    (line_request_s),
        .line_number     (line_number_s),
        .vblank_start    (vblank_start_s),
        .underflow       (underflow_s),
        .underflow_clear (underflow_clear_s),
        .VGA_R           (vga_r_s),
        .VGA_G           (vga_g_s),
        .VGA_B           (vga_b_s),
        .VGA_HS          (vga_hs_s),
        .VGA_VS          (vga_vs_s),
        .VGA_PIXEL_CLOCK (vga_pclk_s)
    );

    // 50 MHz
    initial clk = 1'b0;
    always #10 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;

    geom_t  g_big, g_small;
    model_t mb, ms;
    int     kk;          // clk edges since reset release
    int     pops;        // words consumed from the big pattern source
    bit     pop_pend;    // big instance pops at the coming edge
    bit     first_run;

    // frame-level counters
    int     s_pops, s_hs_low, s_vs_low, s_lr, s_vb;
    int     b_pops, b_hs_low;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Advance one clk; observe and drive 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t obs_big();
        obs_t o;
        o.ready = pixel_ready;  o.pclk = vga_pclk;  o.lr = line_request;
        o.vb    = vblank_start; o.uf   = underflow; o.hs = vga_hs;
        o.vs    = vga_vs;       o.rgb  = {vga_r, vga_g, vga_b};
        o.ln    = line_number;
        return o;
    endfunction

    function automatic obs_t obs_small();
        obs_t o;
        o.ready = pixel_ready_s;  o.pclk = vga_pclk_s;  o.lr = line_request_s;
        o.vb    = vblank_start_s; o.uf   = underflow_s; o.hs = vga_hs_s;
        o.vs    = vga_vs_s;       o.rgb  = {vga_r_s, vga_g_s, vga_b_s};
        o.ln    = line_number_s;
        return o;
    endfunction

    function automatic model_t model_init();
        model_t m;
        m    = '{default: '0};
        m.hs = 1'b1;
        m.vs = 1'b1;
        return m;
    endfunction

    task automatic check_reset_values(input string who, input obs_t o);
        check({who, ".rst_ready"}, o.ready, 0);
        check({who, ".rst_rgb"},   o.rgb,   0);
        check({who, ".rst_hs"},    o.hs,    1);
        check({who, ".rst_vs"},    o.vs,    1);
        check({who, ".rst_pclk"},  o.pclk,  0);
        check({who, ".rst_lreq"},  o.lr,    0);
        check({who, ".rst_lnum"},  o.ln,    0);
        check({who, ".rst_vblk"},  o.vb,    0);
        check({who, ".rst_uflow"}, o.uf,    0);
    endtask

    // Timing model for cycle k (after edge k): apply what edge k loaded,
    // compare, then work out what edge k+1 will load.
    task automatic model_step(input geom_t g, input int k, input obs_t o,
                              input bit valid, input bit clear, input logic [11:0] data,
                              input string who, inout model_t m, output bit ready_exp);
        int ht, vt, dot, h, v, n;
        bit pix_en, act, lr_exp, vb_exp;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;

        if (m.load) begin
            m.rgb = m.rgb_next;
            m.hs  = m.hs_next;
            m.vs  = m.vs_next;
        end
        if (m.set_uf)      m.uf = 1'b1;
        else if (m.clr_uf) m.uf = 1'b0;
        lr_exp = m.lr_pend;
        vb_exp = m.vb_pend;
        if (m.lr_pend) m.ln = m.ln_next;

        pix_en    = (k % g.div) == (g.div - 1);
        dot       = k / g.div;
        h         = dot % ht;
        v         = (dot / ht) % vt;
        act       = (h < g.ha) && (v < g.va);
        ready_exp = pix_en && act;
        n         = (v + 1) % vt;

        check({who, ".ready"}, o.ready, ready_exp);
        check({who, ".pclk"},  o.pclk,  ((k % g.div) >= (g.div / 2)));
        check({who, ".rgb"},   o.rgb,   m.rgb);
        check({who, ".hs"},    o.hs,    m.hs);
        check({who, ".vs"},    o.vs,    m.vs);
        check({who, ".lreq"},  o.lr,    lr_exp);
        check({who, ".lnum"},  o.ln,    m.ln);
        check({who, ".vblk"},  o.vb,    vb_exp);
        check({who, ".uflow"}, o.uf,    m.uf);

        m.load     = pix_en;
        m.rgb_next = (ready_exp && valid) ? data : 12'h000;
        m.hs_next  = !((h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hs));
        m.vs_next  = !((v >= g.va + g.vf) && (v < g.va + g.vf + g.vs));
        m.set_uf   = ready_exp && !valid;
        m.clr_uf   = clear;
        m.lr_pend  = pix_en && (h == g.ha) && (n < g.va);
        m.ln_next  = 10'(n);
        m.vb_pend  = pix_en && (h == 0) && (v == g.va);
    endtask

    task automatic sample_cycle();
        obs_t ob, os;
        bit   rb, rs;
        int   dot_b;
        if (pop_pend) begin
            pops++;
            pixel_data = 12'((pops % 4095) + 1);  // never zero
        end
        // Misses at dots (100,10), (101,10) and (200,11); clears at
        // (101,10) together with a miss, and at (110,10) alone.
        dot_b = kk / 2;
        pixel_valid = !(first_run && (kk % 2 == 1) &&
                        (dot_b == 8100 || dot_b == 8101 || dot_b == 9000));
        underflow_clear = first_run && (kk % 2 == 1) &&
                          (dot_b == 8101 || dot_b == 8110);

        ob = obs_big();
        os = obs_small();
        model_step(g_big, kk, ob, pixel_valid, underflow_clear, pixel_data, "big", mb, rb);
        model_step(g_small, kk, os, pixel_valid_s, underflow_clear_s, pixel_data_s,
                   "small", ms, rs);
        pop_pend = rb && pixel_valid;

        if (kk == 1) check("first_ready_at_clk1", ob.ready, 1);
        if (first_run) begin
            if (kk >= 1 && kk <= 1200) begin
                if (os.ready) s_pops++;
                if (!os.hs)   s_hs_low++;
                if (!os.vs)   s_vs_low++;
                if (os.lr)    s_lr++;
                if (os.vb)    s_vb++;
            end
            if (kk >= 1 && kk <= 3200) begin
                if (ob.ready) b_pops++;
                if (!ob.hs)   b_hs_low++;
            end
            if (kk == 2)            check("first_dot_rgb", ob.rgb, 12'h001);
            if (kk == 2 * 640 + 2) begin
                check("line0_lreq", ob.lr, 1);
                check("line0_lnum", ob.ln, 1);
            end
            if (kk == 2 * 8100 + 2) begin
                check("miss_dot_rgb",  ob.rgb, 0);
                check("miss_dot_flag", ob.uf,  1);
            end
            if (kk == 2 * 8101 + 2) check("miss_beats_clear", ob.uf, 1);
            if (kk == 2 * 8110 + 2) check("clear_alone",      ob.uf, 0);
        end
    endtask

    task automatic start_run();
        kk       = 0;
        mb       = model_init();
        ms       = model_init();
        pop_pend = 1'b0;
        sample_cycle();
    endtask

    initial begin
        g_big   = '{640, 16, 96, 48, 480, 11, 2, 31, 2};
        g_small = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_DIV};

        // NOTE: stimulus is driven with blocking assignments from this
        // process, 1 ns after the edge, so it never races the DUT's flops.
        reset             = 1'b0;
        pixel_data        = 12'h001;
        pixel_valid       = 1'b1;
        underflow_clear   = 1'b0;
        pixel_data_s      = 12'h5A3;
        pixel_valid_s     = 1'b1;
        underflow_clear_s = 1'b0;
        pops      = 0;
        first_run = 1'b1;
        s_pops = 0; s_hs_low = 0; s_vs_low = 0; s_lr = 0; s_vb = 0;
        b_pops = 0; b_hs_low = 0;

        // Power-on reset held for 8 clk.
        for (int i = 0; i < 8; i++) begin
            step();
            check_reset_values("big", obs_big());
            check_reset_values("small", obs_small());
        end

        reset = 1'b1;
        start_run();
        // Run to the pop of dot (300,12) on the big raster.
        while (kk < 19801) begin
            step();
            kk++;
            sample_cycle();
        end

        // Frame-level counts on the small raster over its first two frames.
        check("small_pops_2frames",  s_pops,   96);
        check("small_hs_low_clks",   s_hs_low, 240);
        check("small_vs_low_clks",   s_vs_low, 240);
        check("small_lreq_2frames",  s_lr,     12);
        check("small_vblk_2frames",  s_vb,     2);
        // Line-level counts on the big raster over its first two lines.
        check("big_pops_2lines",     b_pops,   1280);
        check("big_hs_low_2lines",   b_hs_low, 384);

        check("pre_reset_lnum",  line_number, 12);
        check("pre_reset_uflow", underflow,   1);
        check("pre_reset_ready", pixel_ready, 1);

        // Mid-frame asynchronous reset: outputs must drop before any edge.
        reset = 1'b0;
        #1;
        check_reset_values("big", obs_big());
        check_reset_values("small", obs_small());
        first_run = 1'b0;
        pop_pend  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_reset_values("big", obs_big());
            check_reset_values("small", obs_small());
        end

        // Timing restarts at (0,0) with no stray line request.
        reset = 1'b1;
        start_run();
        while (kk < 3300) begin
            step();
            kk++;
            sample_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
